// File: rtl/cacheline_adaptor_if.sv
// cacheline_adaptor_if
//   Bundles the cache-side line port and the memory-side burst port of the
//   cacheline adaptor.
//   Cache side : line_i, line_o, address_i, read_i, write_i, resp_o
//   Memory side: burst_i, burst_o, address_o, read_o, write_o, resp_i
//   Modports:
//     slave  - the adaptor's view (drives *_o, samples *_i)
//     master - the environment's view (drives *_i, samples *_o)
interface cacheline_adaptor_if #(
  parameter int unsigned s_line  = 256,
  parameter int unsigned s_burst = 64,
  parameter int unsigned s_addr  = 32
);
  logic [s_line-1:0]  line_i;
  logic [s_line-1:0]  line_o;
  logic [s_addr-1:0]  address_i;
  logic               read_i;
  logic               write_i;
  logic               resp_o;
  logic [s_burst-1:0] burst_i;
  logic [s_burst-1:0] burst_o;
  logic [s_addr-1:0]  address_o;
  logic               read_o;
  logic               write_o;
  logic               resp_i;

  modport slave (
    input  line_i, address_i, read_i, write_i, burst_i, resp_i,
    output line_o, resp_o, burst_o, address_o, read_o, write_o
  );

  modport master (
    output line_i, address_i, read_i, write_i, burst_i, resp_i,
    input  line_o, resp_o, burst_o, address_o, read_o, write_o
  );
endinterface

// File: rtl/cacheline_adaptor.sv
// cacheline_adaptor
//   Converts one line-wide read or write request from the cache into a burst
//   of s_line/s_burst beats on the physical memory bus and returns a single
//   cycle completion pulse (resp_o). Read beats are reassembled into line_o,
//   write lines are serialised onto burst_o, beat 0 = least-significant word.
//   Ports:
//     clk  - rising-edge clock
//     rst  - synchronous active-low reset
//     bus  - cacheline_adaptor_if.slave (cache and memory handshakes)
//   All outputs are registered.
module cacheline_adaptor #(
  parameter int unsigned s_line   = 256,
  parameter int unsigned s_burst  = 64,
  parameter int unsigned s_addr   = 32,
  parameter int unsigned s_offset = 5
) (
  input  logic               clk,
  input  logic               rst,
  cacheline_adaptor_if.slave bus
);

  localparam int unsigned BEATS = s_line / s_burst;
  localparam int unsigned CW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    DONE
  } state_t;

  // Line storage viewed as an array of beats so beat selection is a plain index.
  typedef logic [BEATS-1:0][s_burst-1:0] line_t;

  state_t             r_state, w_state;
  logic [CW-1:0]      r_count, w_count;
  line_t              r_wline, w_wline;
  line_t              r_rline, w_rline;
  logic [s_burst-1:0] r_burst_o, w_burst_o;
  logic [s_addr-1:0]  r_addr_o, w_addr_o;
  logic               r_read_o, w_read_o;
  logic               r_write_o, w_write_o;
  logic               r_resp_o, w_resp_o;

  logic [CW-1:0]      w_count_inc;
  logic               w_last;
  logic [s_addr-1:0]  w_addr_aligned;
  line_t              w_line_in;

  assign w_count_inc    = r_count + CW'(1);
  assign w_last         = (r_count == CW'(BEATS - 1));
  assign w_addr_aligned = {bus.address_i[s_addr-1:s_offset], {s_offset{1'b0}}};
  assign w_line_in      = bus.line_i;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_count   <= '0;
      r_wline   <= '0;
      r_rline   <= '0;
      r_burst_o <= '0;
      r_addr_o  <= '0;
      r_read_o  <= 1'b0;
      r_write_o <= 1'b0;
      r_resp_o  <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_count   <= w_count;
      r_wline   <= w_wline;
      r_rline   <= w_rline;
      r_burst_o <= w_burst_o;
      r_addr_o  <= w_addr_o;
      r_read_o  <= w_read_o;
      r_write_o <= w_write_o;
      r_resp_o  <= w_resp_o;
    end
  end

  // Next-state logic; write has priority so a dirty line is evicted before refill.
  always_comb begin
    w_state = r_state;
    case (r_state)
      IDLE: begin
        if (bus.write_i)     w_state = WRITE;
        else if (bus.read_i) w_state = READ;
      end
      READ:    if (bus.resp_i && w_last) w_state = DONE;
      WRITE:   if (bus.resp_i && w_last) w_state = DONE;
      DONE:    w_state = IDLE;
      default: w_state = IDLE;
    endcase
  end

  // Next values of the registered outputs and datapath
  always_comb begin
    w_count   = r_count;
    w_wline   = r_wline;
    w_rline   = r_rline;
    w_burst_o = r_burst_o;
    w_addr_o  = r_addr_o;
    w_read_o  = r_read_o;
    w_write_o = r_write_o;
    w_resp_o  = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.write_i) begin
          w_wline   = w_line_in;
          w_addr_o  = w_addr_aligned;
          w_burst_o = w_line_in[0];
          w_write_o = 1'b1;
          w_count   = '0;
        end else if (bus.read_i) begin
          w_addr_o  = w_addr_aligned;
          w_read_o  = 1'b1;
          w_count   = '0;
        end
      end
      READ: begin
        if (bus.resp_i) begin
          w_rline[r_count] = bus.burst_i;
          w_count          = w_count_inc;
          if (w_last) begin
            w_read_o = 1'b0;
            w_resp_o = 1'b1;
          end
        end
      end
      WRITE: begin
        if (bus.resp_i) begin
          w_count = w_count_inc;
          // After the final beat there is no next word; burst_o simply holds.
          if (w_last) begin
            w_write_o = 1'b0;
            w_resp_o  = 1'b1;
          end else begin
            w_burst_o = r_wline[w_count_inc];
          end
        end
      end
      default: ;
    endcase
  end

  assign bus.line_o    = r_rline;
  assign bus.burst_o   = r_burst_o;
  assign bus.address_o = r_addr_o;
  assign bus.read_o    = r_read_o;
  assign bus.write_o   = r_write_o;
  assign bus.resp_o    = r_resp_o;

endmodule

// File: tb/tb_cacheline_adaptor.sv
// tb_cacheline_adaptor
//   Self-checking bench for cacheline_adaptor. Each cache transaction is
//   modelled as a whole: the expected memory address is the request address
//   with its offset bits cleared, write beats are the line's 64-bit words in
//   ascending order, a read line is the concatenation of the returned beats,
//   and exactly one resp_o follows the fourth memory handshake.
module tb_cacheline_adaptor;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  cacheline_adaptor_if bus ();

  cacheline_adaptor dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int unsigned errors = 0;
  int unsigned checks = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] rand_line();
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[32*i +: 32] = $urandom;
    return l;
  endfunction

  // One complete cache transaction. pat/plen give a fixed handshake pattern
  // (bit k = handshake on memory cycle k); plen==0 means random gaps.
  // hold_rd keeps read_i high through the DONE cycle for back-to-back refill.
  task automatic run_txn(input bit wr, input bit rd, input logic [31:0] addr,
                         input logic [255:0] wline, input logic [255:0] rline,
                         input int unsigned gap_pct, input logic [31:0] pat,
                         input int unsigned plen, input bit hold_rd);
    logic [31:0] exp_addr;
    bit          exp_wr;
    bit          h;
    int unsigned beats;
    int unsigned cycles;
    exp_addr      = {addr[31:5], 5'b0};
    exp_wr        = wr;
    bus.address_i = addr;
    bus.line_i    = wline;
    bus.write_i   = wr;
    bus.read_i    = rd;
    bus.resp_i    = 1'b0;
    @(posedge clk); #1;
    check("accept_write_o", bus.write_o, exp_wr);
    check("accept_read_o", bus.read_o, !exp_wr);
    // Request inputs changed after acceptance must have no effect.
    bus.address_i = $urandom;
    bus.line_i    = rand_line();
    beats  = 0;
    cycles = 0;
    while (beats < 4 && cycles < 200) begin
      check("address_o", bus.address_o, exp_addr);
      if (exp_wr) check("burst_o", bus.burst_o, wline[64*beats +: 64]);
      if (plen != 0) h = (cycles < plen) ? pat[cycles] : 1'b1;
      else           h = ($urandom_range(0, 99) >= gap_pct);
      bus.resp_i  = h;
      bus.burst_i = h ? rline[64*beats +: 64] : {$urandom, $urandom};
      @(posedge clk); #1;
      cycles++;
      if (h) beats++;
      if (beats < 4) check("resp_early", bus.resp_o, 1'b0);
    end
    if (beats < 4) begin
      check("burst_timeout", 32'(beats), 32'd4);
    end else begin
      if (gap_pct == 0 && plen == 0) check("latency", 32'(cycles), 32'd4);
      check("resp_o", bus.resp_o, 1'b1);
      check("done_read_o", bus.read_o, 1'b0);
      check("done_write_o", bus.write_o, 1'b0);
      if (!exp_wr) check("line_o", bus.line_o, rline);
    end
    bus.write_i = 1'b0;
    bus.read_i  = hold_rd;
    bus.resp_i  = $urandom_range(0, 1);
    @(posedge clk); #1;
    bus.resp_i = 1'b0;
    check("idle_resp_o", bus.resp_o, 1'b0);
    check("idle_read_o", bus.read_o, 1'b0);
    check("idle_write_o", bus.write_o, 1'b0);
    if (!exp_wr) check("line_o_hold", bus.line_o, rline);
  endtask

  logic [255:0] l0, l1;

  initial begin
    bus.line_i    = '0;
    bus.address_i = '0;
    bus.read_i    = 1'b1;
    bus.write_i   = 1'b0;
    bus.burst_i   = '0;
    bus.resp_i    = 1'b0;

    // Reset held two cycles with a pending read
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_read_o", bus.read_o, 1'b0);
    check("rst_write_o", bus.write_o, 1'b0);
    check("rst_resp_o", bus.resp_o, 1'b0);
    check("rst_address_o", bus.address_o, 32'h0);
    check("rst_burst_o", bus.burst_o, 64'h0);
    check("rst_line_o", bus.line_o, 256'h0);
    bus.read_i = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    check("idle_after_rst", bus.read_o, 1'b0);

    // Zero-gap read
    l0 = {64'h4444444444444444, 64'h3333333333333333,
          64'h2222222222222222, 64'h1111111111111111};
    run_txn(1'b0, 1'b1, 32'h0000_8088, '0, l0, 0, 32'h0, 0, 1'b0);

    // Write with handshake pattern 1,0,1,0,0,1,1
    l1 = {64'hDDDD_0003_DDDD_0003, 64'hCCCC_0002_CCCC_0002,
          64'hBBBB_0001_BBBB_0001, 64'hAAAA_0000_AAAA_0000};
    run_txn(1'b1, 1'b0, 32'h8000_8080, l1, '0, 0, 32'b1100101, 7, 1'b0);

    // Read and write together: write goes first
    run_txn(1'b1, 1'b1, 32'h1234_567F, rand_line(), '0, 30, 32'h0, 0, 1'b0);

    // Dirty evict then refill with read held through resp_o
    run_txn(1'b1, 1'b0, 32'h0000_8080, rand_line(), '0, 0, 32'h0, 0, 1'b1);
    run_txn(1'b0, 1'b1, 32'h8088_8088, '0, rand_line(), 0, 32'h0, 0, 1'b0);

    // Reset after two read beats
    bus.address_i = 32'hCAFE_0040;
    bus.read_i    = 1'b1;
    @(posedge clk); #1;
    check("mid_read_o", bus.read_o, 1'b1);
    for (int i = 0; i < 2; i++) begin
      bus.resp_i  = 1'b1;
      bus.burst_i = {$urandom, $urandom} | 64'h1;
      @(posedge clk); #1;
    end
    bus.read_i = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    check("midrst_read_o", bus.read_o, 1'b0);
    check("midrst_resp_o", bus.resp_o, 1'b0);
    check("midrst_line_o", bus.line_o, 256'h0);
    check("midrst_address_o", bus.address_o, 32'h0);
    rst = 1'b1;
    bus.resp_i = 1'b0;
    @(posedge clk); #1;
    check("midrst_no_resp", bus.resp_o, 1'b0);
    run_txn(1'b0, 1'b1, 32'hCAFE_0040, '0, rand_line(), 0, 32'h0, 0, 1'b0);

    // Randomized transactions
    for (int n = 0; n < 30; n++) begin
      bit wr, rd;
      wr = $urandom_range(0, 1);
      rd = wr ? bit'($urandom_range(0, 1)) : 1'b1;
      run_txn(wr, rd, $urandom, rand_line(), rand_line(),
              $urandom_range(0, 60), 32'h0, 0, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
